// File: rtl/gpio_pio_pkg.sv
// gpio_pio_pkg: shared register map, edge encodings and bus width for the GPIO PIO
package gpio_pio_pkg;
  localparam int BUS_W = 32;
  localparam logic [2:0] ADDR_DATA = 3'd0;
  localparam logic [2:0] ADDR_DIR = 3'd1;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR = 3'd5;
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY = 2;
endpackage

// File: rtl/gpio_sync_edge.sv
// gpio_sync_edge: multi-stage input synchroniser with a delay flop for edge detection
module gpio_sync_edge
  import gpio_pio_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] edge_pulse
);
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] sync_d;
  // shift pads through the synchroniser chain, then one more flop to compare against
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sync_q <= '0;
      sync_d <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      sync_d <= sync_q[SYNC_STAGES-1];
    end
  assign sync_out = sync_q[SYNC_STAGES-1];
  // select which transition counts as an edge
  always_comb
    edge_pulse = EDGE_TYPE == EDGE_FALL ? ~sync_out & sync_d :
                 EDGE_TYPE == EDGE_ANY  ? sync_out ^ sync_d :
                                          sync_out & ~sync_d;
endmodule

// File: rtl/avalon_gpio_pio.sv
// avalon_gpio_pio: Avalon-MM GPIO with direction, set/clear, edge capture and maskable irq
module avalon_gpio_pio
  import gpio_pio_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] OUT_RESET = '0,
  parameter logic [WIDTH-1:0] DIR_RESET = '1,
  parameter int EDGE_TYPE = EDGE_RISE,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe,
  output logic             irq
);
  logic [WIDTH-1:0] data_out, dir, irq_mask, edge_cap, sync_in, edge_pulse, wd, cap_clr, rd;
  logic wr, unused_wd;
  assign wr = chipselect & ~write_n;
  assign wd = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata;
  assign cap_clr = (wr && address == ADDR_EDGE_CAP) ? wd : '0;
  assign out_port = data_out;
  assign oe = dir;
  gpio_sync_edge #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES), .EDGE_TYPE(EDGE_TYPE)) u_sync (
    .clk(clk),
    .reset_n(reset_n),
    .async_in(in_port),
    .sync_out(sync_in),
    .edge_pulse(edge_pulse)
  );
  // register file writes; edge capture lets a new edge win over a same-cycle clear
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      data_out <= OUT_RESET;
      dir <= DIR_RESET;
      irq_mask <= '0;
      edge_cap <= '0;
      irq <= 1'b0;
    end else begin
      if (wr && address == ADDR_DATA) data_out <= wd;
      else if (wr && address == ADDR_OUTSET) data_out <= data_out | wd;
      else if (wr && address == ADDR_OUTCLR) data_out <= data_out & ~wd;
      if (wr && address == ADDR_DIR) dir <= wd;
      if (wr && address == ADDR_IRQ_MASK) irq_mask <= wd;
      edge_cap <= (edge_cap & ~cap_clr) | (edge_pulse & ~dir);
      irq <= |(edge_cap & irq_mask);
    end
  // zero-wait-state read mux; output bits read back the driven value, inputs the pad
  always_comb
    rd = address == ADDR_DATA     ? (data_out & dir) | (sync_in & ~dir) :
         address == ADDR_DIR      ? dir :
         address == ADDR_IRQ_MASK ? irq_mask :
         address == ADDR_EDGE_CAP ? edge_cap :
                                    '0;
  assign readdata = BUS_W'(rd);
endmodule
